v_issue_ctrl: RTL and testbench

Vector instruction issue sequencer between the scalar core's instruction hand-off and the vector execution units (VALU, multiplier, reduction tree, slide unit). It accepts one 32-bit vector instruction with its vector length and decodes it through an internal v_decoder instance. It then steps the instruction across the element array in LANES-wide groups, driving the selected unit's op code with per-group element index and tail mask. It reports completion with a one-cycle done pulse.

---
 rtl/v_pkg.sv | 40 ++++
 rtl/v_decoder.sv | 58 +++++
 rtl/v_issue_ctrl.sv | 168 ++++++++++++++++
 tb/tb_v_issue_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/v_pkg.sv
// Shared types and op-code encodings for the vector issue path.
package v_pkg;

    typedef enum logic [2:0] {IDLE, EXEC, SLDU_WAIT, RED_WAIT, DONE} issue_state_t;
    typedef enum logic [2:0] {U_NONE, U_ALU, U_MUL, U_RED, U_SLDU} unit_sel_t;

    localparam logic [6:0] OP_V     = 7'b1010111;
    localparam logic [2:0] F3_OPIVV = 3'b000;
    localparam logic [2:0] F3_OPMVV = 3'b010;
    localparam logic [2:0] F3_OPIVX = 3'b100;

    localparam logic [5:0] F6_VADD      = 6'b000000;
    localparam logic [5:0] F6_VSUB      = 6'b000010;
    localparam logic [5:0] F6_VAND      = 6'b001001;
    localparam logic [5:0] F6_VOR       = 6'b001010;
    localparam logic [5:0] F6_VXOR      = 6'b001011;
    localparam logic [5:0] F6_VSLIDEUP  = 6'b001110;
    localparam logic [5:0] F6_VSLIDEDN  = 6'b001111;
    localparam logic [5:0] F6_VREDSUM   = 6'b000000;
    localparam logic [5:0] F6_VREDMIN   = 6'b000101;
    localparam logic [5:0] F6_VREDMAX   = 6'b000111;
    localparam logic [5:0] F6_VMUL      = 6'b100101;

    localparam logic [3:0] VALU_NOP  = 4'd0;
    localparam logic [3:0] VALU_VADD = 4'd1;
    localparam logic [3:0] VALU_VSUB = 4'd2;
    localparam logic [3:0] VALU_VAND = 4'd3;
    localparam logic [3:0] VALU_VOR  = 4'd4;
    localparam logic [3:0] VALU_VXOR = 4'd5;

    localparam logic [2:0] VRED_NOP     = 3'd0;
    localparam logic [2:0] VRED_VREDSUM = 3'd1;
    localparam logic [2:0] VRED_VREDMAX = 3'd2;
    localparam logic [2:0] VRED_VREDMIN = 3'd3;

    localparam logic [2:0] VSLDU_NOP  = 3'd0;
    localparam logic [2:0] VSLDU_UP   = 3'd1;
    localparam logic [2:0] VSLDU_DOWN = 3'd2;

endpackage

// File: rtl/v_decoder.sv
// Combinational decode of a 32-bit vector instruction into per-unit op codes.
module v_decoder
    import v_pkg::*;
#(
    parameter int OFF = 0
) (
    input  logic [OFF+31:0] word,
    output logic [3:0]      alu_op,
    output logic            mul_en,
    output logic [2:0]      red_op,
    output logic [2:0]      sldu_op
);

    logic [31:0] ins;
    logic [5:0]  f6;
    logic [2:0]  f3;
    logic [15:0] unused_fields;

    assign ins           = word[OFF +: 32];
    assign f6            = ins[31:26];
    assign f3            = ins[14:12];
    assign unused_fields = {ins[25:15], ins[11:7]};

    always_comb begin
        alu_op  = VALU_NOP;
        mul_en  = 1'b0;
        red_op  = VRED_NOP;
        sldu_op = VSLDU_NOP;
        if (ins[6:0] == OP_V) begin
            case (f3)
                F3_OPIVV, F3_OPIVX: begin
                    case (f6)
                        F6_VADD:     alu_op = VALU_VADD;
                        F6_VSUB:     alu_op = VALU_VSUB;
                        F6_VAND:     alu_op = VALU_VAND;
                        F6_VOR:      alu_op = VALU_VOR;
                        F6_VXOR:     alu_op = VALU_VXOR;
                        // slides only exist in the scalar-operand form
                        F6_VSLIDEUP: if (f3 == F3_OPIVX) sldu_op = VSLDU_UP;
                        F6_VSLIDEDN: if (f3 == F3_OPIVX) sldu_op = VSLDU_DOWN;
                        default: ;
                    endcase
                end
                F3_OPMVV: begin
                    case (f6)
                        F6_VREDSUM: red_op = VRED_VREDSUM;
                        F6_VREDMIN: red_op = VRED_VREDMIN;
                        F6_VREDMAX: red_op = VRED_VREDMAX;
                        F6_VMUL:    mul_en = 1'b1;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/v_issue_ctrl.sv
// Vector issue sequencer: decodes one instruction and steps it across the
// element array in LANES-wide groups, with slide/reduction completion waits.
module v_issue_ctrl
    import v_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int VLMAX   = 32,
    parameter int RED_LAT = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       instr_valid,
    output logic                       instr_ready,
    input  logic [31:0]                instr,
    input  logic [$clog2(VLMAX):0]     vl,
    input  logic                       exec_stall,
    input  logic                       sldu_done,
    output logic                       grp_valid,
    output logic [$clog2(VLMAX)-1:0]   elem_idx,
    output logic [LANES-1:0]           elem_mask,
    output logic [3:0]                 alu_op,
    output logic                       mul_en,
    output logic [2:0]                 red_op,
    output logic [2:0]                 sldu_op,
    output logic                       busy,
    output logic                       done,
    output logic                       illegal
);

    localparam int IW = $clog2(VLMAX);
    localparam int VW = IW + 1;
    localparam int RW = (RED_LAT > 1) ? $clog2(RED_LAT) : 1;

    issue_state_t state;
    unit_sel_t    unit_q, sel;
    logic [31:0]  instr_q, instr_sel;
    logic [VW-1:0] vl_q, vl_sat;
    logic [RW-1:0] red_cnt;
    logic [3:0]   dec_alu;
    logic         dec_mul;
    logic [2:0]   dec_red, dec_sldu;
    logic         last_grp;

    function automatic logic [LANES-1:0] tail_mask(input int base, input int len);
        logic [LANES-1:0] m;
        for (int i = 0; i < LANES; i++) m[i] = (base + i) < len;
        return m;
    endfunction

    // Decode must be ready at the accepting edge, so feed the live instruction while idle.
    assign instr_sel = instr_ready ? instr : instr_q;
    assign vl_sat    = (int'(vl) > VLMAX) ? VW'(VLMAX) : vl;
    assign last_grp  = (int'(elem_idx) + LANES) >= int'(vl_q);

    v_decoder #(.OFF(0)) u_dec (
        .word    (instr_sel),
        .alu_op  (dec_alu),
        .mul_en  (dec_mul),
        .red_op  (dec_red),
        .sldu_op (dec_sldu)
    );

    always_comb begin
        sel = U_NONE;
        if (dec_sldu != VSLDU_NOP)    sel = U_SLDU;
        else if (dec_red != VRED_NOP) sel = U_RED;
        else if (dec_mul)             sel = U_MUL;
        else if (dec_alu != VALU_NOP) sel = U_ALU;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            unit_q      <= U_NONE;
            instr_q     <= '0;
            vl_q        <= '0;
            red_cnt     <= '0;
            instr_ready <= 1'b1;
            grp_valid   <= 1'b0;
            elem_idx    <= '0;
            elem_mask   <= '0;
            alu_op      <= '0;
            mul_en      <= 1'b0;
            red_op      <= '0;
            sldu_op     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        instr_q <= instr;
                        vl_q    <= vl_sat;
                        unit_q  <= sel;
                        if (sel == U_NONE) begin
                            illegal <= 1'b1;
                        end else if (vl_sat == '0) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            busy        <= 1'b1;
                            instr_ready <= 1'b0;
                        end else begin
                            state       <= EXEC;
                            busy        <= 1'b1;
                            instr_ready <= 1'b0;
                            grp_valid   <= 1'b1;
                            elem_idx    <= '0;
                            elem_mask   <= tail_mask(0, int'(vl_sat));
                            alu_op      <= (sel == U_ALU)  ? dec_alu  : 4'd0;
                            mul_en      <= (sel == U_MUL);
                            red_op      <= (sel == U_RED)  ? dec_red  : 3'd0;
                            sldu_op     <= (sel == U_SLDU) ? dec_sldu : 3'd0;
                        end
                    end
                end
                EXEC: begin
                    if (!exec_stall) begin
                        if (unit_q == U_SLDU || last_grp) begin
                            grp_valid <= 1'b0;
                            elem_idx  <= '0;
                            elem_mask <= '0;
                            alu_op    <= '0;
                            mul_en    <= 1'b0;
                            red_op    <= '0;
                            sldu_op   <= '0;
                            if (unit_q == U_SLDU) begin
                                state <= SLDU_WAIT;
                            end else if (unit_q == U_RED) begin
                                state   <= RED_WAIT;
                                red_cnt <= RW'(RED_LAT - 1);
                            end else begin
                                state <= DONE;
                                done  <= 1'b1;
                            end
                        end else begin
                            elem_idx  <= elem_idx + IW'(LANES);
                            elem_mask <= tail_mask(int'(elem_idx) + LANES, int'(vl_q));
                        end
                    end
                end
                SLDU_WAIT: begin
                    if (sldu_done) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                RED_WAIT: begin
                    if (red_cnt == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        red_cnt <= red_cnt - 1'b1;
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    instr_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_v_issue_ctrl.sv
// Directed bench for v_issue_ctrl: inputs change and outputs are checked on the
// falling edge; cycle N+k is the interval after the k-th rising edge from accept.
module tb_v_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [5:0]  vl;
    logic        exec_stall;
    logic        sldu_done;
    logic        grp_valid;
    logic [4:0]  elem_idx;
    logic [3:0]  elem_mask;
    logic [3:0]  alu_op;
    logic        mul_en;
    logic [2:0]  red_op;
    logic [2:0]  sldu_op;
    logic        busy;
    logic        done;
    logic        illegal;

    int checks   = 0;
    int failures = 0;

    v_issue_ctrl #(.LANES(4), .VLMAX(32), .RED_LAT(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .vl          (vl),
        .exec_stall  (exec_stall),
        .sldu_done   (sldu_done),
        .grp_valid   (grp_valid),
        .elem_idx    (elem_idx),
        .elem_mask   (elem_mask),
        .alu_op      (alu_op),
        .mul_en      (mul_en),
        .red_op      (red_op),
        .sldu_op     (sldu_op),
        .busy        (busy),
        .done        (done),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic [5:0] f6, input logic [2:0] f3);
        return {f6, 1'b1, 5'd2, 5'd1, f3, 5'd3, 7'b1010111};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic grp(input string tag, input logic [4:0] idx, input logic [3:0] mask);
        chk({tag, "_valid"}, 32'(grp_valid), 32'd1);
        chk({tag, "_idx"}, 32'(elem_idx), 32'(idx));
        chk({tag, "_mask"}, 32'(elem_mask), 32'(mask));
    endtask

    // Offer at the current falling edge; returns at the falling edge of cycle N+1.
    task automatic issue(input logic [31:0] ins, input logic [5:0] len);
        instr_valid = 1'b1;
        instr       = ins;
        vl          = len;
        @(negedge clk);
        instr_valid = 1'b0;
        instr       = 32'hFFFF_FFFF;
    endtask

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instr = '0; vl = '0;
        exec_stall = 1'b0; sldu_done = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(instr_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grp", 32'(grp_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;

        // stray sldu_done while idle
        sldu_done = 1'b1;
        @(negedge clk);
        sldu_done = 1'b0;
        chk("stray_busy", 32'(busy), 32'd0);
        chk("stray_done", 32'(done), 32'd0);
        @(negedge clk);
        chk("stray_done2", 32'(done), 32'd0);

        // vadd.vv vl=10
        issue(enc(6'b000000, 3'b000), 6'd10);
        grp("vadd_g0", 5'd0, 4'b1111);
        chk("vadd_alu", 32'(alu_op), 32'd1);
        chk("vadd_mul", 32'(mul_en), 32'd0);
        chk("vadd_ready", 32'(instr_ready), 32'd0);
        @(negedge clk);
        grp("vadd_g1", 5'd4, 4'b1111);
        @(negedge clk);
        grp("vadd_g2", 5'd8, 4'b0011);
        chk("vadd_done_early", 32'(done), 32'd0);
        @(negedge clk);
        chk("vadd_done", 32'(done), 32'd1);
        chk("vadd_grp_off", 32'(grp_valid), 32'd0);
        chk("vadd_alu_off", 32'(alu_op), 32'd0);
        chk("vadd_busy_done", 32'(busy), 32'd1);
        @(negedge clk);
        chk("vadd_ready_back", 32'(instr_ready), 32'd1);
        chk("vadd_done_pulse", 32'(done), 32'd0);

        // vmul vl=8 with stall in N+2
        issue(enc(6'b100101, 3'b010), 6'd8);
        grp("vmul_g0", 5'd0, 4'b1111);
        chk("vmul_en0", 32'(mul_en), 32'd1);
        chk("vmul_alu0", 32'(alu_op), 32'd0);
        @(negedge clk);
        grp("vmul_g1", 5'd4, 4'b1111);
        exec_stall = 1'b1;
        @(negedge clk);
        exec_stall = 1'b0;
        grp("vmul_held", 5'd4, 4'b1111);
        chk("vmul_en2", 32'(mul_en), 32'd1);
        chk("vmul_nodone", 32'(done), 32'd0);
        @(negedge clk);
        chk("vmul_done", 32'(done), 32'd1);
        @(negedge clk);

        // vredsum vl=4, RED_LAT=2
        issue(enc(6'b000000, 3'b010), 6'd4);
        grp("vred_g0", 5'd0, 4'b1111);
        chk("vred_op", 32'(red_op), 32'd1);
        chk("vred_alu", 32'(alu_op), 32'd0);
        @(negedge clk);
        chk("vred_w1_grp", 32'(grp_valid), 32'd0);
        chk("vred_w1_done", 32'(done), 32'd0);
        chk("vred_w1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("vred_w2_grp", 32'(grp_valid), 32'd0);
        chk("vred_w2_done", 32'(done), 32'd0);
        @(negedge clk);
        chk("vred_done", 32'(done), 32'd1);
        @(negedge clk);

        // vslideup.vx vl=16; sldu_done coincident with the group is ignored
        issue(enc(6'b001110, 3'b100), 6'd16);
        grp("vsl_g0", 5'd0, 4'b1111);
        chk("vsl_op", 32'(sldu_op), 32'd1);
        sldu_done = 1'b1;
        @(negedge clk);
        sldu_done = 1'b0;
        chk("vsl_w2_grp", 32'(grp_valid), 32'd0);
        chk("vsl_w2_op", 32'(sldu_op), 32'd0);
        @(negedge clk);
        chk("vsl_w3_done", 32'(done), 32'd0);
        @(negedge clk);
        chk("vsl_w4_done", 32'(done), 32'd0);
        @(negedge clk);
        chk("vsl_w5_done", 32'(done), 32'd0);
        chk("vsl_w5_busy", 32'(busy), 32'd1);
        sldu_done = 1'b1;
        @(negedge clk);
        sldu_done = 1'b0;
        chk("vsl_done", 32'(done), 32'd1);
        chk("vsl_busy6", 32'(busy), 32'd1);
        @(negedge clk);
        chk("vsl_idle", 32'(busy), 32'd0);

        // undecodable funct6
        issue(enc(6'b111111, 3'b000), 6'd8);
        chk("ill_pulse", 32'(illegal), 32'd1);
        chk("ill_busy", 32'(busy), 32'd0);
        chk("ill_done", 32'(done), 32'd0);
        chk("ill_ready", 32'(instr_ready), 32'd1);
        @(negedge clk);
        chk("ill_pulse_end", 32'(illegal), 32'd0);
        chk("ill_done2", 32'(done), 32'd0);
        chk("ill_busy2", 32'(busy), 32'd0);

        // legal op with vl=0
        issue(enc(6'b000010, 3'b000), 6'd0);
        chk("vl0_done", 32'(done), 32'd1);
        chk("vl0_grp", 32'(grp_valid), 32'd0);
        @(negedge clk);
        chk("vl0_grp2", 32'(grp_valid), 32'd0);
        chk("vl0_ready", 32'(instr_ready), 32'd1);

        // vl=40 saturates to 32: eight full groups, last at 28
        issue(enc(6'b001011, 3'b000), 6'd40);
        chk("sat_alu", 32'(alu_op), 32'd5);
        for (int g = 0; g < 8; g++) begin
            grp("sat_g", 5'(4 * g), 4'b1111);
            @(negedge clk);
        end
        chk("sat_done", 32'(done), 32'd1);
        @(negedge clk);

        // async reset mid-EXEC of vl=32 vadd
        issue(enc(6'b000000, 3'b000), 6'd32);
        @(negedge clk);
        grp("abort_g1", 5'd4, 4'b1111);
        #2 rst = 1'b1;
        #1;
        chk("abort_grp", 32'(grp_valid), 32'd0);
        chk("abort_ready", 32'(instr_ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_alu", 32'(alu_op), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_nodone", 32'(done), 32'd0);
        chk("abort_idle", 32'(busy), 32'd0);
        issue(enc(6'b000000, 3'b000), 6'd5);
        grp("post_g0", 5'd0, 4'b1111);
        @(negedge clk);
        grp("post_g1", 5'd4, 4'b0001);
        @(negedge clk);
        chk("post_done", 32'(done), 32'd1);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
